// File: rtl/lc3b_shf_pkg.sv
// lc3b_shf_pkg: shared state encoding, sizes and shift-mode encodings for the SHF datapath.
package lc3b_shf_pkg;
  localparam int SHF_WIDTH = 16;
  localparam int SHF_AMT_W = 4;
  localparam logic SHF_LOGICAL = 1'b0;
  localparam logic SHF_ARITH = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/rshf1_step.sv
// rshf1_step: combinational single-position right shift with optional sign fill.
module rshf1_step
  import lc3b_shf_pkg::*;
#(
  parameter int WIDTH = SHF_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             arith,
  output logic [WIDTH-1:0] shifted
);
  assign shifted = {(arith == SHF_ARITH) & value[WIDTH-1], value[WIDTH-1:1]};
endmodule

// File: rtl/rshf_seq.sv
// rshf_seq: iterative 16-bit right shifter, one position per clock, start/ready/done handshake.
// Optional macro RSHF_LSHF_EN adds a dir input selecting left shift.
module rshf_seq
  import lc3b_shf_pkg::*;
#(
  parameter int WIDTH = SHF_WIDTH,
  parameter int AMT_W = SHF_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] amount,
  input  logic             arith,
`ifdef RSHF_LSHF_EN
  input  logic             dir,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);
  state_t state, state_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] out_n, rstep, step;
  logic mode, mode_n, accept;
  assign ready = (state == IDLE) || (state == DONE);
  assign busy = state == SHIFT;
  assign done = state == DONE;
  assign accept = start && ready;
  rshf1_step #(.WIDTH(WIDTH)) u_step (.value(out), .arith(mode), .shifted(rstep));
`ifdef RSHF_LSHF_EN
  logic dir_q, dir_n;
  assign step = dir_q ? {out[WIDTH-2:0], 1'b0} : rstep;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dir_q <= 1'b0;
    else dir_q <= dir_n;
  always_comb dir_n = accept ? dir : dir_q;
`else
  assign step = rstep;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out <= '0;
      cnt <= '0;
      mode <= SHF_LOGICAL;
    end else begin
      state <= state_n;
      out <= out_n;
      cnt <= cnt_n;
      mode <= mode_n;
    end
  end
  // cnt reaches 1 on the final shift, so it never underflows
  always_comb begin
    state_n = state;
    out_n = out;
    cnt_n = cnt;
    mode_n = mode;
    if (accept) begin
      out_n = in;
      cnt_n = amount;
      mode_n = arith;
      state_n = (amount == '0) ? DONE : SHIFT;
    end else if (state == SHIFT) begin
      out_n = step;
      cnt_n = cnt - 1'b1;
      state_n = (cnt == AMT_W'(1)) ? DONE : SHIFT;
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
endmodule

// File: tb/tb_rshf_seq.sv
// tb_rshf_seq: directed table-driven bench for rshf_seq plus protocol and reset sequences.
module tb_rshf_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, arith = 1'b0;
  logic [15:0] in = '0;
  logic [3:0] amount = '0;
  logic ready, busy, done;
  logic [15:0] out;
`ifdef RSHF_LSHF_EN
  logic dir = 1'b0;
`endif
  int checks = 0, failures = 0;

  rshf_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in), .amount(amount), .arith(arith),
`ifdef RSHF_LSHF_EN
    .dir(dir),
`endif
    .ready(ready), .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [3:0] n;
    logic ar;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller sits at #1 after a posedge; accept happens at the next posedge.
  task automatic run_op(input logic [15:0] a, input logic [3:0] n, input logic ar, input logic dr,
                        input bit noise, output logic [15:0] res, output int lat, output int bc,
                        output logic acc_done);
    @(negedge clk);
    acc_done = done;
    start = 1'b1; in = a; amount = n; arith = ar;
`ifdef RSHF_LSHF_EN
    dir = dr;
`else
    if (dr) $display("dir ignored in default build");
`endif
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bc = 0;
    while (!done && lat < 40) begin
      bc += busy;
      if (noise) begin
        start = busy; in = 16'hFFFF; amount = 4'd3; arith = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    res = out;
  endtask

  vec_t tbl[8];
  logic [15:0] res;
  int lat, bc;
  logic ad;

  initial begin
    tbl[0] = '{16'h8001, 4'd1, 1'b0, 16'h4000};
    tbl[1] = '{16'h8001, 4'd4, 1'b1, 16'hF800};
    tbl[2] = '{16'h7FF0, 4'd4, 1'b1, 16'h07FF};
    tbl[3] = '{16'h1234, 4'd0, 1'b0, 16'h1234};
    tbl[4] = '{16'h8000, 4'd15, 1'b1, 16'hFFFF};
    tbl[5] = '{16'h8000, 4'd15, 1'b0, 16'h0001};
    tbl[6] = '{16'hF0F0, 4'd8, 1'b1, 16'hFFF0};
    tbl[7] = '{16'hF0F0, 4'd8, 1'b0, 16'h00F0};

    #2;
    check("rst_out", 32'(out), 0);
    check("rst_ready", 32'(ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].n, tbl[i].ar, 1'b0, 1'b0, res, lat, bc, ad);
      check($sformatf("v%0d_out", i), 32'(res), 32'(tbl[i].exp));
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].n) + 1);
      check($sformatf("v%0d_busy", i), 32'(bc), 32'(tbl[i].n));
      repeat (2) @(posedge clk);
      #1;
    end

    // start while busy is ignored, then back-to-back accept in the DONE cycle
    run_op(16'h0F00, 4'd8, 1'b0, 1'b0, 1'b1, res, lat, bc, ad);
    check("ign_out", 32'(res), 32'h000F);
    check("ign_lat", 32'(lat), 9);
    run_op(16'h00F0, 4'd2, 1'b0, 1'b0, 1'b0, res, lat, bc, ad);
    check("b2b_in_done", 32'(ad), 1);
    check("b2b_out", 32'(res), 32'h003C);
    check("b2b_lat", 32'(lat), 3);
    repeat (2) @(posedge clk);
    #1;

    // async reset during a 10-cycle op
    @(negedge clk);
    start = 1'b1; in = 16'h0123; amount = 4'd10; arith = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mrst_out", 32'(out), 0);
    check("mrst_done", 32'(done), 0);
    check("mrst_ready", 32'(ready), 1);
    check("mrst_busy", 32'(busy), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(ready), 1);
    run_op(16'h0010, 4'd4, 1'b0, 1'b0, 1'b0, res, lat, bc, ad);
    check("post_rst_out", 32'(res), 32'h0001);
    check("post_rst_lat", 32'(lat), 5);

`ifdef RSHF_LSHF_EN
    repeat (2) @(posedge clk);
    #1;
    run_op(16'h0001, 4'd15, 1'b0, 1'b1, 1'b0, res, lat, bc, ad);
    check("lshf_out", 32'(res), 32'h8000);
    check("lshf_lat", 32'(lat), 16);
    repeat (2) @(posedge clk);
    #1;
    run_op(16'h8001, 4'd1, 1'b1, 1'b1, 1'b0, res, lat, bc, ad);
    check("lshf_ar_out", 32'(res), 32'h0002);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
